// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and the capture decoder.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int SEG7_W = 7;

  localparam logic [SEG7_W-1:0] SEG7_BLANK = 7'b1111111;

  localparam logic [SEG7_W-1:0] SEG7_CODE [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the hex-to-segment table: segment pattern back to a nibble.
// hit flags a legal code, blank flags the all-off pattern.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG7_W-1:0] seg,
  output logic              hit,
  output logic              blank,
  output logic [3:0]        val
);

  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_CODE[i]) begin
        hit = 1'b1;
        val = 4'(i);
      end
    end
  end

  assign blank = (seg == SEG7_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Capture side of the multiplexed display: sync, deglitch, decode
// each scanned digit and flag complete frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NDIG-1:0]     an,
  input  logic [SEG7_W-1:0]   seg,
  input  logic                clr,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     dig_valid,
  output logic [NDIG-1:0]     bad_pat,
  output logic                multi_an,
  output logic                frame_stb
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int NW = $clog2(NDIG + 1);

  logic [NDIG-1:0]   an_s1, an_s2;
  logic [SEG7_W-1:0] seg_s1, seg_s2;
  logic [CNT_W-1:0]  cnt;
  logic [NDIG-1:0]   seen;

  logic              chg, cap;
  logic              hit, blank;
  logic [3:0]        val;
  logic [NW-1:0]     nlow;
  logic [IW-1:0]     idx;
  logic              cap_one, cap_multi;
  logic [NDIG-1:0]   capbit, seen_nxt;

  seg7_pattern_decode u_dec (
    .seg   (seg_s2),
    .hit   (hit),
    .blank (blank),
    .val   (val)
  );

  // chg looks one stage ahead so the counter restarts as the new
  // value lands in the second sync flop
  assign chg = {an_s1, seg_s1} != {an_s2, seg_s2};
  assign cap = !chg && (cnt == CNT_W'(STABLE_CYC - 1));

  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_s2[i]) begin
        nlow = nlow + NW'(1);
        idx  = IW'(i);
      end
    end
  end

  assign cap_one   = cap && (nlow == NW'(1));
  assign cap_multi = cap && (nlow > NW'(1));
  assign capbit    = (cap_one && hit) ? ~an_s2 : '0;
  assign seen_nxt  = seen | capbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1     <= '1;
      an_s2     <= '1;
      seg_s1    <= '1;
      seg_s2    <= '1;
      cnt       <= '0;
      seen      <= '0;
      digits    <= '0;
      dig_valid <= '0;
      bad_pat   <= '0;
      multi_an  <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      an_s1     <= an;
      an_s2     <= an_s1;
      seg_s1    <= seg;
      seg_s2    <= seg_s1;
      frame_stb <= 1'b0;
      if (chg)
        cnt <= '0;
      else if (cnt != CNT_W'(STABLE_CYC))
        cnt <= cnt + CNT_W'(1);
      if (clr) begin
        dig_valid <= '0;
        bad_pat   <= '0;
        multi_an  <= 1'b0;
        seen      <= '0;
      end else begin
        if (cap_multi)
          multi_an <= 1'b1;
        if (cap_one && hit) begin
          digits[4*idx +: 4] <= val;
          dig_valid[idx]     <= 1'b1;
          if (&seen_nxt) begin
            frame_stb <= 1'b1;
            seen      <= '0;
          end else begin
            seen <= seen_nxt;
          end
        end else if (cap_one && !blank) begin
          bad_pat[idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed table, corner
// sequences and randomized scans against a transaction-level model.
module tb_seg7_scan_decoder;

  localparam int NDIG = 4;
  localparam int STABLE_CYC = 4;

  localparam logic [6:0] CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [10:0] IDLE = 11'h7ff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic [3:0]  bad_pat;
  logic        multi_an;
  logic        frame_stb;

  int ncmp = 0;
  int nerr = 0;
  int nfr  = 0;

  seg7_scan_decoder #(
    .NDIG(NDIG), .STABLE_CYC(STABLE_CYC), .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .clr(clr),
    .digits(digits), .dig_valid(dig_valid), .bad_pat(bad_pat),
    .multi_an(multi_an), .frame_stb(frame_stb)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_stb) nfr++;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         hold;
    logic [3:0] d0;
    logic [3:0] bad;
    logic       multi;
  } vec_t;

  vec_t tv [20];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold a pattern for n clocks; returns 1 ns after the last edge.
  task automatic drive(input logic [3:0] a, input logic [6:0] s,
                       input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one accepted sample per held pattern.
  logic [3:0] m_dig [4];
  logic [3:0] m_valid, m_bad, m_seen;
  logic       m_multi;
  int         m_frames;

  function automatic int find_code(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (CODES[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_dig[k] = '0;
    m_valid = '0; m_bad = '0; m_seen = '0;
    m_multi = 1'b0; m_frames = 0;
  endtask

  task automatic model_accept(input logic [3:0] a, input logic [6:0] s);
    int k, v;
    if (a == 4'hf) return;
    if ($countones(~a) > 1) begin
      m_multi = 1'b1;
      return;
    end
    k = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) k = i;
    v = find_code(s);
    if (v >= 0) begin
      m_dig[k] = 4'(v);
      m_valid[k] = 1'b1;
      m_seen[k] = 1'b1;
      if (m_seen == 4'hf) begin
        m_frames++;
        m_seen = '0;
      end
    end else if (s != 7'h7f) begin
      m_bad[k] = 1'b1;
    end
  endtask

  task automatic do_reset();
    an = '1; seg = '1; clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, base, fbase;
    logic [3:0]  ra;
    logic [6:0]  rs;
    logic [10:0] last;
    logic [15:0] exp_d;
    int          n;

    rst_n = 1'b0; an = '1; seg = '1; clr = 1'b0;
    #12;
    chk("reset_digits", 32'(digits), 0);
    chk("reset_flags", {dig_valid, bad_pat, multi_an, frame_stb}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'hf, 7'h7f, 3);

    // change-to-update latency
    an = 4'b1110; seg = CODES[5]; lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (digits[3:0] == 4'h5) break;
    end
    chk("latency", lat, 2 + STABLE_CYC);

    // directed table: every code on digit 0, then blank/bad/multi/idle
    for (int i = 0; i < 16; i++)
      tv[i] = '{4'b1110, CODES[i], 6, 4'(i), 4'b0000, 1'b0};
    tv[16] = '{4'b1110, 7'b1111111, 6, 4'hf, 4'b0000, 1'b0};
    tv[17] = '{4'b1101, 7'b1010101, 6, 4'hf, 4'b0010, 1'b0};
    tv[18] = '{4'b1100, CODES[1], 6, 4'hf, 4'b0010, 1'b1};
    tv[19] = '{4'b1111, CODES[3], 6, 4'hf, 4'b0010, 1'b1};
    for (int i = 0; i < 20; i++) begin
      drive(tv[i].an, tv[i].seg, tv[i].hold);
      chk($sformatf("tv%0d_d0", i), 32'(digits[3:0]), 32'(tv[i].d0));
      chk($sformatf("tv%0d_bad", i), 32'(bad_pat), 32'(tv[i].bad));
      chk($sformatf("tv%0d_multi", i), 32'(multi_an), 32'(tv[i].multi));
    end
    chk("tv_valid0", 32'(dig_valid[0]), 1);

    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_flags", {dig_valid, bad_pat, multi_an}, 0);
    chk("clr_keeps_d0", 32'(digits[3:0]), 32'hf);

    // glitchy segments never settle long enough
    for (int i = 0; i < 10; i++)
      drive(4'b1110, (i % 2) ? CODES[7] : CODES[2], 2);
    chk("glitch_d0", 32'(digits[3:0]), 32'hf);
    drive(4'b1110, 7'b0001000, 6);
    chk("glitch_then_a", 32'(digits[3:0]), 32'ha);

    // full scan of 0123
    fbase = nfr;
    drive(4'b1110, 7'b0110000, 6);
    drive(4'b1101, 7'b0100100, 6);
    drive(4'b1011, 7'b1111001, 6);
    drive(4'b0111, 7'b1000000, 6);
    chk("scan_stb_with_digit", 32'(frame_stb), 1);
    drive(4'hf, 7'h7f, 3);
    chk("scan_digits", 32'(digits), 32'h0123);
    chk("scan_valid", 32'(dig_valid), 32'hf);
    chk("scan_frames", nfr - fbase, 1);

    // clr lands on the capture edge of the last digit
    fbase = nfr;
    drive(4'b1110, CODES[4], 6);
    drive(4'b1101, CODES[5], 6);
    drive(4'b1011, CODES[6], 6);
    drive(4'b0111, CODES[9], 5);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clrcap_stb", 32'(frame_stb), 0);
    chk("clrcap_valid", 32'(dig_valid), 0);
    drive(4'b0111, CODES[9], 3);
    chk("clrcap_d3_kept", 32'(digits[15:12]), 0);
    drive(4'hf, 7'h7f, 6);
    drive(4'b0111, CODES[9], 6);
    drive(4'hf, 7'h7f, 3);
    chk("clrcap_recap_d3", 32'(digits[15:12]), 9);
    chk("clrcap_recap_valid", 32'(dig_valid), 32'h8);
    chk("clrcap_no_frame", nfr - fbase, 0);

    // reset in the middle of a scan
    drive(4'b1110, CODES[1], 6);
    drive(4'b1101, CODES[2], 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_digits", 32'(digits), 0);
    chk("midrst_flags", {dig_valid, bad_pat, multi_an, frame_stb}, 0);
    an = '1; seg = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = nfr;
    drive(4'b1101, CODES[2], 6);
    drive(4'b1011, CODES[3], 6);
    drive(4'b0111, CODES[4], 6);
    drive(4'hf, 7'h7f, 3);
    chk("midrst_partial", nfr - base, 0);
    drive(4'b1110, CODES[5], 6);
    drive(4'hf, 7'h7f, 3);
    chk("midrst_full", nfr - base, 1);
    chk("midrst_digits2", 32'(digits), 32'h4325);

    // randomized scans against the model
    do_reset();
    model_reset();
    base = nfr;
    last = IDLE;
    for (int g = 0; g < 60; g++) begin
      for (int h = 0; h < 6; h++) begin
        do begin
          case ($urandom_range(0, 9))
            0: ra = 4'hf;
            1: begin
              do ra = 4'($urandom); while ($countones(~ra) < 2);
            end
            default: ra = ~(4'b0001 << $urandom_range(0, 3));
          endcase
          case ($urandom_range(0, 9))
            0: rs = 7'h7f;
            1: rs = 7'($urandom);
            default: rs = CODES[$urandom_range(0, 15)];
          endcase
        end while ({ra, rs} == last || {ra, rs} == IDLE);
        last = {ra, rs};
        n = $urandom_range(0, 1) ? $urandom_range(1, 3)
                                 : $urandom_range(STABLE_CYC + 2, 10);
        drive(ra, rs, n);
        if (n >= STABLE_CYC + 2) model_accept(ra, rs);
      end
      drive(4'hf, 7'h7f, 8);
      last = IDLE;
      if (g % 5 == 4) begin
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        m_valid = '0; m_bad = '0; m_multi = 1'b0; m_seen = '0;
      end
      for (int k = 0; k < 4; k++) exp_d[4*k +: 4] = m_dig[k];
      chk($sformatf("rnd%0d_digits", g), 32'(digits), 32'(exp_d));
      chk($sformatf("rnd%0d_valid", g), 32'(dig_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_bad", g), 32'(bad_pat), 32'(m_bad));
      chk($sformatf("rnd%0d_multi", g), 32'(multi_an), 32'(m_multi));
      chk($sformatf("rnd%0d_frames", g), nfr - base, m_frames);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
